conv_kernel_engine: RTL and testbench

Frame-based 3x3 convolution engine for the tactile sensor grid. It has a runtime-writable bank of NUM_KERNELS coefficient sets, selectable edge handling (zero-pad or clamp), and an optional absolute-value output mode. It reads raw taxel values from the input BRAM and writes filtered values to the output BRAM, one full frame per start pulse. It is the parametrised successor of the fixed six-kernel computation block and sits between the scan-capture BRAM and the display/readout BRAM.

---
 rtl/conv_kernel_engine.sv | 208 ++++++++++++++++++++
 tb/tb_conv_kernel_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_kernel_engine.sv
// rtl/conv_kernel_engine.sv - frame-based 3x3 convolution engine with a runtime-writable kernel bank
module conv_kernel_engine #(
  parameter int SW_WIRE_CNT = 16,
  parameter int RD_WIRE_CNT = 16,
  parameter int DATA_W      = 12,
  parameter int NUM_KERNELS = 8,
  localparam int KW  = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
  localparam int AW  = $clog2(SW_WIRE_CNT * RD_WIRE_CNT),
  localparam int SWW = $clog2(SW_WIRE_CNT),
  localparam int RDW = $clog2(RD_WIRE_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_select,
  input  logic              edge_mode,
  input  logic              abs_mode,
  input  logic              cfg_we,
  input  logic [KW-1:0]     cfg_kernel,
  input  logic [3:0]        cfg_idx,
  input  logic [7:0]        cfg_data,
  output logic [AW-1:0]     in_bram_addr,
  input  logic [DATA_W-1:0] in_bram_data,
  output logic              out_we,
  output logic [AW-1:0]     out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [SWW-1:0]    sw_wires,
  output logic [RDW-1:0]    rd_wires,
  output logic              busy,
  output logic              done
);

  // Accumulator is wide enough for 9 taps of max data times max |coeff|.
  localparam int ACC_W = DATA_W + 13;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state;

  // Kernel bank: nine signed taps plus an arithmetic right shift per set.
  logic signed [7:0] coef [NUM_KERNELS][9];
  logic [3:0]        shift_bank [NUM_KERNELS];

  // Frame settings captured at start.
  logic [KW-1:0] k_lat;
  logic          edge_lat;
  logic          abs_lat;

  // Pixel / tap currently being addressed.
  logic [SWW-1:0] cur_sw;
  logic [RDW-1:0] cur_rd;
  logic [3:0]     cur_tap;

  // Tap geometry for the current address.
  int      tap_r, tap_c, tap_rc, tap_cc;
  logic    tap_inside;
  logic [AW-1:0] tap_addr;

  // One-cycle pipeline stage aligned with the BRAM read latency.
  logic          s1_valid;
  logic [3:0]    s1_tap;
  logic          s1_use;
  logic          s1_last;
  logic [AW-1:0] s1_pix;

  logic signed [ACC_W-1:0] acc, acc_next, dwide, cwide, prod, shifted, mag;
  logic signed [7:0]       cur_coef;
  logic [DATA_W-1:0]       sat_val;

  assign sw_wires     = cur_sw;
  assign rd_wires     = cur_rd;
  assign in_bram_addr = (state == RUN) ? tap_addr : '0;

  // Map the current tap to grid coordinates, with clamping used both for clamp mode and to keep zero-pad addresses in range.
  always_comb begin
    tap_r      = int'(cur_sw) + int'(cur_tap) / 3 - 1;
    tap_c      = int'(cur_rd) + int'(cur_tap) % 3 - 1;
    tap_inside = (tap_r >= 0) && (tap_r < SW_WIRE_CNT) && (tap_c >= 0) && (tap_c < RD_WIRE_CNT);
    tap_rc     = (tap_r < 0) ? 0 : ((tap_r > SW_WIRE_CNT - 1) ? SW_WIRE_CNT - 1 : tap_r);
    tap_cc     = (tap_c < 0) ? 0 : ((tap_c > RD_WIRE_CNT - 1) ? RD_WIRE_CNT - 1 : tap_c);
    tap_addr   = AW'(tap_rc * RD_WIRE_CNT + tap_cc);
  end

  // Multiply-accumulate on returning read data, then shift, optional magnitude and saturation.
  always_comb begin
    cur_coef = coef[k_lat][s1_tap];
    dwide    = {{(ACC_W - DATA_W){1'b0}}, in_bram_data};
    cwide    = {{(ACC_W - 8){cur_coef[7]}}, cur_coef};
    prod     = s1_use ? (dwide * cwide) : '0;
    acc_next = ((s1_tap == 4'd0) ? '0 : acc) + prod;
    shifted  = acc_next >>> shift_bank[k_lat];
    mag      = (abs_lat && shifted[ACC_W-1]) ? -shifted : shifted;
    if (mag[ACC_W-1])
      sat_val = '0;
    else if (|mag[ACC_W-2:DATA_W])
      sat_val = '1;
    else
      sat_val = mag[DATA_W-1:0];
  end

  // Kernel bank: identity on reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_KERNELS; k++) begin
        for (int t = 0; t < 9; t++)
          coef[k][t] <= (t == 4) ? 8'sd1 : 8'sd0;
        shift_bank[k] <= 4'd0;
      end
    end else if (state == IDLE && cfg_we && (int'(cfg_kernel) < NUM_KERNELS)) begin
      if (cfg_idx < 4'd9)
        coef[cfg_kernel][cfg_idx] <= cfg_data;
      else if (cfg_idx == 4'd9)
        shift_bank[cfg_kernel] <= cfg_data[3:0];
    end
  end

  // Frame sequencer: walks pixels and taps, latches settings, drives busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_sw   <= '0;
      cur_rd   <= '0;
      cur_tap  <= '0;
      k_lat    <= '0;
      edge_lat <= 1'b0;
      abs_lat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            k_lat    <= (int'(k_select) < NUM_KERNELS) ? k_select : '0;
            edge_lat <= edge_mode;
            abs_lat  <= abs_mode;
            cur_sw   <= '0;
            cur_rd   <= '0;
            cur_tap  <= '0;
          end
        end
        RUN: begin
          if (cur_tap == 4'd8) begin
            if (cur_rd == RDW'(RD_WIRE_CNT - 1)) begin
              if (cur_sw == SWW'(SW_WIRE_CNT - 1)) begin
                state <= DRAIN;
              end else begin
                cur_tap <= '0;
                cur_rd  <= '0;
                cur_sw  <= cur_sw + 1'b1;
              end
            end else begin
              cur_tap <= '0;
              cur_rd  <= cur_rd + 1'b1;
            end
          end else begin
            cur_tap <= cur_tap + 1'b1;
          end
        end
        DRAIN: begin
          if (out_we) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          cur_sw  <= '0;
          cur_rd  <= '0;
          cur_tap <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency stage, accumulator and output write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tap   <= '0;
      s1_use   <= 1'b0;
      s1_last  <= 1'b0;
      s1_pix   <= '0;
      acc      <= '0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      s1_valid <= (state == RUN);
      s1_tap   <= cur_tap;
      s1_use   <= tap_inside | edge_lat;
      s1_last  <= (cur_tap == 4'd8);
      s1_pix   <= AW'(int'(cur_sw) * RD_WIRE_CNT + int'(cur_rd));
      if (s1_valid)
        acc <= acc_next;
      out_we <= s1_valid && s1_last;
      if (s1_valid && s1_last) begin
        out_addr <= s1_pix;
        out_data <= sat_val;
      end
    end
  end

endmodule

// File: tb/tb_conv_kernel_engine.sv
// tb/tb_conv_kernel_engine.sv - self-checking bench for conv_kernel_engine on a 4x4 grid
module tb_conv_kernel_engine;
  localparam int SW = 4;
  localparam int RD = 4;
  localparam int N  = SW * RD;
  localparam int DW = 12;
  localparam int NK = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    k_select;
  logic          edge_mode;
  logic          abs_mode;
  logic          cfg_we;
  logic [2:0]    cfg_kernel;
  logic [3:0]    cfg_idx;
  logic [7:0]    cfg_data;
  logic [3:0]    in_bram_addr;
  logic [DW-1:0] in_bram_data;
  logic          out_we;
  logic [3:0]    out_addr;
  logic [DW-1:0] out_data;
  logic [1:0]    sw_wires;
  logic [1:0]    rd_wires;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  int mem [N];
  int mcoef [NK][9];
  int mshift [NK];

  int cyc = 0;
  int t0 = 0;
  bit mon_en = 0;
  int rel_m;
  int got [N];
  int wc [N];
  int nwr, ndone, done_rel, busy_first, busy_last, busy_at_done, late_wr, pos46;

  conv_kernel_engine #(
    .SW_WIRE_CNT(SW), .RD_WIRE_CNT(RD), .DATA_W(DW), .NUM_KERNELS(NK)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_select(k_select),
    .edge_mode(edge_mode), .abs_mode(abs_mode), .cfg_we(cfg_we),
    .cfg_kernel(cfg_kernel), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .in_bram_addr(in_bram_addr), .in_bram_data(in_bram_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .sw_wires(sw_wires), .rd_wires(rd_wires), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) in_bram_data <= DW'(mem[in_bram_addr]);

  always @(negedge clk) begin
    if (mon_en) begin
      rel_m = cyc - t0;
      if (out_we) begin
        got[out_addr] = int'(out_data);
        wc[out_addr]  = rel_m;
        nwr++;
        if (rel_m > 40) late_wr++;
      end
      if (done) begin
        ndone++;
        done_rel     = rel_m;
        busy_at_done = int'(busy);
      end
      if (busy) begin
        if (busy_first < 0) busy_first = rel_m;
        busy_last = rel_m;
      end
      if (rel_m == 46) pos46 = int'({sw_wires, rd_wires});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      for (int t = 0; t < 9; t++) mcoef[k][t] = (t == 4) ? 1 : 0;
      mshift[k] = 0;
    end
  endtask

  function automatic int model_pix(int r, int c, int ks, int em, int am);
    int acc = 0;
    int rr, cc;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr < 0 || rr >= SW || cc < 0 || cc >= RD) begin
          if (em == 0) continue;
          rr = (rr < 0) ? 0 : ((rr >= SW) ? SW - 1 : rr);
          cc = (cc < 0) ? 0 : ((cc >= RD) ? RD - 1 : cc);
        end
        acc += mem[rr * RD + cc] * mcoef[ks][(dr + 1) * 3 + dc + 1];
      end
    end
    acc = acc >>> mshift[ks];
    if (am != 0 && acc < 0) acc = -acc;
    if (acc < 0) return 0;
    if (acc > 4095) return 4095;
    return acc;
  endfunction

  task automatic cfg_write(input int k, input int i, input int d);
    @(negedge clk);
    cfg_we = 1; cfg_kernel = 3'(k); cfg_idx = 4'(i); cfg_data = 8'(d);
    @(negedge clk);
    cfg_we = 0;
    if (i < 9) mcoef[k][i] = d;
    else if (i == 9) mshift[k] = d & 15;
  endtask

  // mode: 0 plain, 1 disturbed by cfg/start pulses, 2 cfg write in the start cycle, 3 reset at cycle 40
  task automatic run_frame(input int ks, input int em, input int am, input int mode);
    for (int p = 0; p < N; p++) begin got[p] = -1; wc[p] = -1; end
    nwr = 0; ndone = 0; done_rel = -1; busy_first = -1; busy_last = -1;
    busy_at_done = -1; late_wr = 0; pos46 = -1;
    @(negedge clk);
    k_select = 3'(ks); edge_mode = em[0]; abs_mode = am[0]; start = 1;
    if (mode == 2) begin
      cfg_we = 1; cfg_kernel = 3'(ks); cfg_idx = 4'd4; cfg_data = 8'd2;
      mcoef[ks][4] = 2;
    end
    t0 = cyc;
    mon_en = 1;
    for (int i = 1; i < 9 * N + 20; i++) begin
      @(negedge clk);
      if (mode == 1 && (i == 20 || i == 60 || i == 100 || i == 147)) begin
        start = 1; cfg_we = 1; cfg_kernel = 3'(ks); cfg_idx = 4'd4; cfg_data = 8'hFB;
        k_select = 3'(ks ^ 1); edge_mode = ~edge_mode; abs_mode = ~abs_mode;
      end else begin
        start = 0; cfg_we = 0;
      end
      rst = (mode == 3 && i == 40);
    end
    @(negedge clk);
    start = 0; cfg_we = 0; rst = 0;
    mon_en = 0;
  endtask

  task automatic check_frame(input string tag, input int ks, input int em, input int am);
    for (int p = 0; p < N; p++) begin
      chk($sformatf("%s_val%0d", tag, p), got[p], model_pix(p / RD, p % RD, ks, em, am));
      chk($sformatf("%s_wcyc%0d", tag, p), wc[p], 9 * p + 11);
    end
    chk({tag, "_writes"}, nwr, N);
    chk({tag, "_done_cnt"}, ndone, 1);
    chk({tag, "_done_cyc"}, done_rel, 9 * N + 3);
    chk({tag, "_busy_first"}, busy_first, 1);
    chk({tag, "_busy_last"}, busy_last, 9 * N + 2);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    chk({tag, "_pos46"}, pos46, 5);
  endtask

  initial begin
    rst = 1; start = 0; k_select = 0; edge_mode = 0; abs_mode = 0;
    cfg_we = 0; cfg_kernel = 0; cfg_idx = 0; cfg_data = 0;
    for (int p = 0; p < N; p++) mem[p] = p;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_out_we", out_we, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sw", sw_wires, 0);
    chk("rst_rd", rd_wires, 0);
    chk("rst_in_addr", in_bram_addr, 0);

    // identity on addr ramp
    run_frame(0, 0, 0, 0);
    check_frame("ident", 0, 0, 0);
    chk("ident_pix9", got[9], 9);

    // all-ones kernel, constant 100, zero-pad then clamp
    for (int t = 0; t < 9; t++) cfg_write(1, t, 1);
    cfg_write(1, 9, 0);
    for (int p = 0; p < N; p++) mem[p] = 100;
    run_frame(1, 0, 0, 0);
    check_frame("ones_zp", 1, 0, 0);
    chk("ones_zp_corner", got[0], 400);
    chk("ones_zp_edge", got[1], 600);
    chk("ones_zp_inner", got[5], 900);
    run_frame(1, 1, 0, 0);
    check_frame("ones_cl", 1, 1, 0);
    chk("ones_cl_corner", got[15], 900);

    // Laplacian impulse response, plain and magnitude
    for (int t = 0; t < 9; t++) cfg_write(2, t, (t == 4) ? -8 : 1);
    for (int p = 0; p < N; p++) mem[p] = 0;
    mem[5] = 1000;
    run_frame(2, 0, 0, 0);
    check_frame("lap", 2, 0, 0);
    chk("lap_centre", got[5], 0);
    chk("lap_neigh", got[0], 1000);
    run_frame(2, 0, 1, 0);
    check_frame("lap_abs", 2, 0, 1);
    chk("lap_abs_centre", got[5], 4095);

    // randomized kernel, shift, data and modes; idx 10..15 writes must be ignored
    for (int r = 0; r < 3; r++) begin
      int em, am;
      for (int t = 0; t < 9; t++) cfg_write(3, t, $signed(8'($urandom)));
      cfg_write(3, 9, int'($urandom_range(0, 255)));
      cfg_write(3, 10 + int'($urandom_range(0, 5)), int'($urandom_range(0, 255)));
      for (int p = 0; p < N; p++) mem[p] = int'($urandom_range(0, 4095));
      em = int'($urandom_range(0, 1));
      am = int'($urandom_range(0, 1));
      run_frame(3, em, am, 0);
      check_frame($sformatf("rnd%0d", r), 3, em, am);
    end

    // mid-frame cfg_we / start / setting changes must not disturb the frame
    for (int p = 0; p < N; p++) mem[p] = int'($urandom_range(0, 4095));
    run_frame(1, 0, 0, 1);
    check_frame("disturb", 1, 0, 0);
    edge_mode = 0; abs_mode = 0;

    // cfg write in the same cycle as start is used by that frame
    run_frame(4, 0, 0, 2);
    check_frame("cfg_at_start", 4, 0, 0);

    // reset at cycle 40 abandons the frame and restores identity kernels
    run_frame(1, 0, 0, 3);
    model_reset();
    chk("rst40_late_writes", late_wr, 0);
    chk("rst40_done_cnt", ndone, 0);
    chk("rst40_writes", nwr, 4);
    chk("rst40_busy", busy, 0);
    for (int p = 0; p < N; p++) mem[p] = int'($urandom_range(0, 4095));
    run_frame(1, 0, 0, 0);
    check_frame("after_rst", 1, 0, 0);
    chk("after_rst_pix6", got[6], mem[6]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
